// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: groups the byte strobe input and the key/event outputs of
// the PS/2 key decoder. The master modport belongs to the byte source and event
// consumer side. The slave modport belongs to the decoder.
interface ps2_key_decoder_if #(
  parameter int OUT_W = 6
);
  logic             ps2InValid;
  logic [7:0]       ps2InCode;
  logic [OUT_W-1:0] ps2OutCode;
  logic             ps2OutHeld;
  logic             ps2EvValid;
  logic [OUT_W-1:0] ps2EvCode;
  logic             ps2EvMake;
  logic             ps2EvExt;
  logic             ps2Unmapped;

  modport master (
    output ps2InValid, ps2InCode,
    input  ps2OutCode, ps2OutHeld, ps2EvValid, ps2EvCode, ps2EvMake, ps2EvExt,
           ps2Unmapped
  );

  modport slave (
    input  ps2InValid, ps2InCode,
    output ps2OutCode, ps2OutHeld, ps2EvValid, ps2EvCode, ps2EvMake, ps2EvExt,
           ps2Unmapped
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns a PS/2 scancode byte stream into a held-key code and
// one-cycle key events. It tracks the E0/F0 prefix context, with a timeout that
// discards a prefix that is left hanging.
// Optional feature: define PS2_TYPEMATIC_FILTER_EN to suppress repeat makes of
// the key that is already held.
module ps2_key_decoder #(
  parameter int                         OUT_W          = 6,
  parameter int                         NUM_KEYS       = 7,
  parameter logic [NUM_KEYS*8-1:0]      KEY_CODES      = {8'h32, 8'h34, 8'h2D, 8'h25,
                                                          8'h26, 8'h1E, 8'h16},
  parameter logic [NUM_KEYS*OUT_W-1:0]  KEY_VALUES     = {6'h03, 6'h02, 6'h01, 6'h30,
                                                          6'h20, 6'h10, 6'h00},
  parameter logic [OUT_W-1:0]           IDLE_CODE      = {OUT_W{1'b1}},
  parameter int                         TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  ps2_key_decoder_if.slave bus
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [OUT_W-1:0] r_out_code, w_out_code_nxt;
  logic             r_out_held, w_out_held_nxt;
  logic             r_ev_valid, w_ev_valid_nxt;
  logic [OUT_W-1:0] r_ev_code, w_ev_code_nxt;
  logic             r_ev_make, w_ev_make_nxt;
  logic             r_ev_ext, w_ev_ext_nxt;
  logic             r_unmapped, w_unmapped_nxt;

  logic             w_hit;
  logic [OUT_W-1:0] w_val;
  logic             w_is_e0, w_is_f0;
  logic             w_proc, w_brk, w_ext, w_rep, w_timeout;

  assign w_is_e0 = (bus.ps2InCode == 8'hE0);
  assign w_is_f0 = (bus.ps2InCode == 8'hF0);

  // Table lookup: scan from the top down so that the lowest matching index wins.
  always_comb begin
    w_hit = 1'b0;
    w_val = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (bus.ps2InCode == KEY_CODES[8*i +: 8]) begin
        w_hit = 1'b1;
        w_val = KEY_VALUES[OUT_W*i +: OUT_W];
      end
    end
  end

  // Repeat make of the key already held (dropped only when the filter is built in).
`ifdef PS2_TYPEMATIC_FILTER_EN
  assign w_rep = r_out_held && (w_val == r_out_code);
`else
  assign w_rep = 1'b0;
`endif

  // A prefix expires when its count is used up and no byte arrives in that cycle.
  assign w_timeout = (r_state != S_IDLE) && !bus.ps2InValid && (r_cnt == TO_LAST);

  // Next-state, timeout counter and next values of the registered outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_out_code_nxt = r_out_code;
    w_out_held_nxt = r_out_held;
    w_ev_valid_nxt = 1'b0;
    w_ev_code_nxt  = r_ev_code;
    w_ev_make_nxt  = r_ev_make;
    w_ev_ext_nxt   = r_ev_ext;
    w_unmapped_nxt = 1'b0;
    w_proc         = 1'b0;
    w_brk          = 1'b0;
    w_ext          = 1'b0;

    if (bus.ps2InValid) begin
      w_cnt_nxt = '0;
      case (r_state)
        S_IDLE: begin
          if (w_is_e0)      w_state_nxt = S_EXT;
          else if (w_is_f0) w_state_nxt = S_BRK;
          else              w_proc      = 1'b1;
        end
        S_EXT: begin
          if (w_is_f0)       w_state_nxt = S_EXT_BRK;
          else if (!w_is_e0) begin
            w_proc = 1'b1; w_ext = 1'b1; w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (w_is_e0)       w_state_nxt = S_EXT_BRK;
          else if (!w_is_f0) begin
            w_proc = 1'b1; w_brk = 1'b1; w_state_nxt = S_IDLE;
          end
        end
        default: begin
          if (!w_is_e0 && !w_is_f0) begin
            w_proc = 1'b1; w_brk = 1'b1; w_ext = 1'b1; w_state_nxt = S_IDLE;
          end
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state != S_IDLE && r_cnt != TO_LAST) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    if (w_proc) begin
      if (!w_hit) begin
        w_unmapped_nxt = 1'b1;
      end else if (w_brk) begin
        w_ev_valid_nxt = 1'b1;
        w_ev_code_nxt  = w_val;
        w_ev_make_nxt  = 1'b0;
        w_ev_ext_nxt   = w_ext;
        if (r_out_held && (w_val == r_out_code)) begin
          w_out_code_nxt = IDLE_CODE;
          w_out_held_nxt = 1'b0;
        end
      end else if (!w_rep) begin
        w_ev_valid_nxt = 1'b1;
        w_ev_code_nxt  = w_val;
        w_ev_make_nxt  = 1'b1;
        w_ev_ext_nxt   = w_ext;
        w_out_code_nxt = w_val;
        w_out_held_nxt = 1'b1;
      end
    end
  end

  // State, counter and output registers; reset overrides any byte in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_out_code <= IDLE_CODE;
      r_out_held <= 1'b0;
      r_ev_valid <= 1'b0;
      r_ev_code  <= '0;
      r_ev_make  <= 1'b0;
      r_ev_ext   <= 1'b0;
      r_unmapped <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_out_code <= w_out_code_nxt;
      r_out_held <= w_out_held_nxt;
      r_ev_valid <= w_ev_valid_nxt;
      r_ev_code  <= w_ev_code_nxt;
      r_ev_make  <= w_ev_make_nxt;
      r_ev_ext   <= w_ev_ext_nxt;
      r_unmapped <= w_unmapped_nxt;
    end
  end

  assign bus.ps2OutCode  = r_out_code;
  assign bus.ps2OutHeld  = r_out_held;
  assign bus.ps2EvValid  = r_ev_valid;
  assign bus.ps2EvCode   = r_ev_code;
  assign bus.ps2EvMake   = r_ev_make;
  assign bus.ps2EvExt    = r_ev_ext;
  assign bus.ps2Unmapped = r_unmapped;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sequential, parametrised successor to the combinational PS/2 scancode mapper.
- Consumes byte strobes from the PS/2 receiver.
- Tracks the make (press), break (F0) and extended (E0) prefix context and maps scancodes through a parameter table.
- Drives the VGA control path with:
  - a held-key code, which shows the idle value when no key is held;
  - a one-cycle key event strobe carrying make/break and extended flags.

Parameters:
- OUT_W, 6: width of the mapped output code.
- NUM_KEYS, 7: number of table entries, 1..16.
- KEY_CODES, {8'h32,8'h34,8'h2D,8'h25,8'h26,8'h1E,8'h16}: flattened NUM_KEYS*8 scancode table; entry i is in bits [8i+7:8i].
- KEY_VALUES, {6'h03,6'h02,6'h01,6'h30,6'h20,6'h10,6'h00}: flattened NUM_KEYS*OUT_W mapped values; entry i pairs with KEY_CODES entry i.
- IDLE_CODE, {OUT_W{1'b1}}: value of ps2OutCode when no mapped key is held.
- TIMEOUT_CYCLES, 50000: clock cycles a prefix state may wait for its next byte; must be ≥2.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- ps2InValid, input, 1: one-cycle strobe; ps2InCode is valid.
- ps2InCode, input, 8: received scancode byte.
- ps2OutCode, output, OUT_W: currently held mapped key, or IDLE_CODE.
- ps2OutHeld, output, 1: a mapped key is currently held.
- ps2EvValid, output, 1: one-cycle key event strobe.
- ps2EvCode, output, OUT_W: mapped value of the event key.
- ps2EvMake, output, 1: 1 = press, 0 = release; qualified by ps2EvValid.
- ps2EvExt, output, 1: event key was E0-prefixed; qualified by ps2EvValid.
- ps2Unmapped, output, 1: one-cycle strobe; a non-prefix byte missed the table.

Behaviour:
- Reset values (synchronous, active-high; reset wins over every other event):
  - ps2OutCode = IDLE_CODE; ps2OutHeld = 0.
  - ps2EvValid = 0; ps2EvCode = 0; ps2EvMake = 0; ps2EvExt = 0; ps2Unmapped = 0.
  - FSM = IDLE; timeout counter = 0.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- Transitions are evaluated only when ps2InValid = 1:
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> process as make, ext=0, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> process as make, ext=1, -> IDLE.
  - BRK: other -> process as break, ext=0, -> IDLE; F0 -> stay BRK; E0 -> EXT_BRK.
  - EXT_BRK: other -> process as break, ext=1, -> IDLE; E0/F0 -> stay.
- Lookup:
  - Parallel compare of the byte against all NUM_KEYS entries.
  - If several entries match, the lowest index wins.
  - The extended flag does not take part in the lookup.
- Make, on a table hit:
  - ps2EvValid = 1, ps2EvCode = value, ps2EvMake = 1, ps2EvExt = ext.
  - ps2OutCode = value; ps2OutHeld = 1. The last pressed key replaces any earlier held key.
- Break, on a table hit:
  - ps2EvValid = 1, ps2EvMake = 0, ps2EvCode = value, ps2EvExt = ext.
  - If value equals ps2OutCode and ps2OutHeld = 1: ps2OutCode = IDLE_CODE and ps2OutHeld = 0. Otherwise the held state is unchanged.
- Table miss on a make or break byte:
  - No event is generated.
  - ps2Unmapped pulses for one cycle.
  - The held state is unchanged and the FSM returns to IDLE.
- Latency:
  - All outputs are registered.
  - An event appears exactly 1 cycle after the ps2InValid cycle.
  - ps2EvValid and ps2Unmapped are high for exactly one cycle each.
  - ps2EvCode, ps2EvMake and ps2EvExt hold their last values between events.
- Timeout:
  - The counter clears on every ps2InValid and counts every cycle spent in a non-IDLE state.
  - When it reaches TIMEOUT_CYCLES-1 with no ps2InValid that cycle, the FSM -> IDLE silently (no strobes) and the counter clears.
  - If a byte arrives in the same cycle the count would expire, the byte is processed in the prefix context and the timeout does not occur.
  - The counter saturates and does not wrap.
- Back-to-back: ps2InValid on consecutive cycles must be accepted; each byte is processed in the state left by the previous byte.
- Reset mid-sequence, for example after an F0: the prefix is discarded; the next byte is treated as a make in IDLE.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - A make whose value equals ps2OutCode while ps2OutHeld = 1 produces no event and no ps2Unmapped pulse.
  - The FSM still returns to IDLE and the timeout counter still clears.
- Undefined: every typematic repeat make produces a full make event.

Test Plan:
1. Press and release "1": reset, then bytes 16 / F0 16 -> make event (code 00, make=1, ext=0) 1 cycle after the 16; ps2OutCode = 00, held = 1; then break event (code 00, make=0) and ps2OutCode returns to 3F, held = 0.
2. Extended make: bytes E0 2D -> event code 01, make=1, ext=1; bytes E0 F0 2D -> event code 01, make=0, ext=1; ps2OutCode ends at 3F.
3. Overlapping keys and unmapped byte:
   - Bytes 1E 26 F0 1E -> ps2OutCode = 20 after the 26, and stays 20 after the break of 1E.
   - Byte 1C -> ps2Unmapped pulses for one cycle, no event.
4. Prefix timeout, with TIMEOUT_CYCLES = 8:
   - F0 then idle for 8 cycles then 34 -> make event code 02, not a break.
   - Second run: F0 with 34 arriving on the expiry cycle -> break event.
5. Typematic repeat: bytes 32 32 32 back-to-back on consecutive cycles -> with PS2_TYPEMATIC_FILTER_EN, 1 event; without it, 3 events on 3 consecutive cycles.
6. Reset mid-sequence: bytes F0, then reset, then 25 -> make event code 30, held = 1. Also assert reset in the same cycle as ps2InValid -> all outputs at reset values and no event.
